// File: rtl/peripheral_bus_master_pkg.sv
// Shared definitions for the peripheral bus initiator: FSM encoding, bus widths
// and the value returned when no responder supplies read data.
package peripheral_bus_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } pb_state_e;

  localparam int          PB_ADDR_W        = 24;
  localparam int          PB_DATA_W        = 32;
  localparam int          PB_SEL_W         = 4;
  localparam logic [31:0] BUS_DEFAULT_READ = 32'hFFFF_FFFF;

  // Upper address byte selects the peripheral window.
  function automatic logic window_hit(input logic [31:0] adr, input logic [7:0] high);
    return adr[31:24] == high;
  endfunction

endpackage

// File: rtl/peripheral_bus_timeout.sv
// Busy-stall counter for the peripheral bus initiator: clears on demand, counts
// enabled cycles, saturates, and flags when the stall limit is reached.
module peripheral_bus_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Raised during the last permitted stall cycle so the FSM leaves ACCESS on
  // exactly the TIMEOUT_CYCLES-th busy cycle.
  assign expired = (count_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/peripheral_bus_master.sv
// Wishbone classic slave to peripheral bus initiator; one access in flight.
// Optional busy-stall timeout and unclaimed-read error: PERIPHERAL_BUS_TIMEOUT_EN.
module peripheral_bus_master
  import peripheral_bus_master_pkg::*;
#(
  parameter logic [7:0] ADDRESS_HIGH   = 8'h13,
  parameter int         TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_cyc_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_we_i,
  input  logic [PB_SEL_W-1:0]  wb_sel_i,
  input  logic [31:0]          wb_adr_i,
  input  logic [PB_DATA_W-1:0] wb_dat_i,
  output logic                 wb_ack_o,
  output logic                 wb_err_o,
  output logic [PB_DATA_W-1:0] wb_dat_o,
  output logic                 peripheralBus_we,
  output logic                 peripheralBus_oe,
  input  logic                 peripheralBus_busy,
  output logic [PB_ADDR_W-1:0] peripheralBus_address,
  output logic [PB_SEL_W-1:0]  peripheralBus_byteSelect,
  output logic [PB_DATA_W-1:0] peripheralBus_dataWrite,
  input  logic [PB_DATA_W-1:0] peripheralBus_dataRead,
  input  logic                 requestOutput
);

  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  pb_state_e             state_q, state_d;
  logic [PB_ADDR_W-1:0]  adr_q;
  logic [PB_SEL_W-1:0]   sel_q;
  logic [PB_DATA_W-1:0]  wdat_q;
  logic                  we_q;
  logic                  err_q;
  logic                  req_hit;
  logic                  in_access;
  logic                  timed_out;
  logic                  claim_err;

  function automatic logic [PB_DATA_W-1:0] resolve_read(input logic claimed,
                                                        input logic [PB_DATA_W-1:0] data);
    return claimed ? data : BUS_DEFAULT_READ;
  endfunction

  assign req_hit   = wb_cyc_i & wb_stb_i & window_hit(wb_adr_i, ADDRESS_HIGH);
  assign in_access = (state_q == ACCESS);

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  logic stall_expired;

  peripheral_bus_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (!in_access),
    .enable (in_access & peripheralBus_busy),
    .expired(stall_expired)
  );

  assign timed_out = stall_expired & peripheralBus_busy;
  assign claim_err = ~we_q & ~requestOutput;
`else
  assign timed_out = 1'b0;
  assign claim_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_hit) state_d = ACCESS;
      end
      ACCESS: begin
        // A dropped cycle abandons the access silently.
        if (!wb_cyc_i)               state_d = IDLE;
        else if (!peripheralBus_busy) state_d = RESP;
        else if (timed_out)           state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and response data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q    <= '0;
      sel_q    <= '0;
      wdat_q   <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      if ((state_q == IDLE) && req_hit) begin
        adr_q  <= wb_adr_i[PB_ADDR_W-1:0];
        sel_q  <= wb_sel_i;
        wdat_q <= wb_dat_i;
        we_q   <= wb_we_i;
      end
      if (in_access && wb_cyc_i) begin
        if (!peripheralBus_busy) begin
          err_q <= claim_err;
          if (!we_q) wb_dat_o <= resolve_read(requestOutput, peripheralBus_dataRead);
        end else if (timed_out) begin
          err_q    <= 1'b1;
          wb_dat_o <= BUS_DEFAULT_READ;
        end
      end
    end
  end

  assign peripheralBus_we         = in_access & we_q;
  assign peripheralBus_oe         = in_access & ~we_q;
  assign peripheralBus_address    = adr_q;
  assign peripheralBus_byteSelect = sel_q;
  assign peripheralBus_dataWrite  = wdat_q;
  assign wb_ack_o                 = (state_q == RESP) & ~err_q;
  assign wb_err_o                 = (state_q == RESP) & err_q;

endmodule

// File: tb/tb_peripheral_bus_master.sv
// Scoreboard bench for peripheral_bus_master: driver pushes expected responses,
// a monitor pops them on each ack/err, a responder model drives busy.
module tb_peripheral_bus_master;

  localparam int TO = 16;
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]  wb_sel = '0;
  logic [31:0] wb_adr = '0, wb_wdat = '0;
  logic        wb_ack, wb_err;
  logic [31:0] wb_rdat;
  logic        pb_we, pb_oe;
  logic        pb_busy = 1'b0;
  logic [23:0] pb_adr;
  logic [3:0]  pb_sel;
  logic [31:0] pb_wdat;
  logic [31:0] pb_rdat = '0;
  logic        req_out = 1'b0;

  always #5 clk = ~clk;

  peripheral_bus_master #(.ADDRESS_HIGH(8'h13), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst_n),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_wdat),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err), .wb_dat_o(wb_rdat),
    .peripheralBus_we(pb_we), .peripheralBus_oe(pb_oe), .peripheralBus_busy(pb_busy),
    .peripheralBus_address(pb_adr), .peripheralBus_byteSelect(pb_sel),
    .peripheralBus_dataWrite(pb_wdat), .peripheralBus_dataRead(pb_rdat),
    .requestOutput(req_out)
  );

  typedef struct { bit err; logic [31:0] dat; } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] model_dat = '0;

  // Responder configuration and expected strobe contents for the current access.
  int          cfg_busy = 0;
  bit          chk_strobe = 1'b0;
  bit          cur_we = 1'b0;
  logic [23:0] cur_adr = '0;
  logic [3:0]  cur_sel = '0;
  logic [31:0] cur_dat = '0;
  int          strobe_cnt = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Responder: holds busy for cfg_busy strobe cycles, then releases.
  int  rem = 0;
  bit  active = 1'b0;
  always @(negedge clk) begin
    if (pb_we || pb_oe) begin
      strobe_cnt++;
      if (!active) begin
        active = 1'b1;
        rem = cfg_busy;
      end
      if (chk_strobe) begin
        check32("strobe_addr", {8'h0, pb_adr}, {8'h0, cur_adr});
        check32("strobe_sel", {28'h0, pb_sel}, {28'h0, cur_sel});
        check32("strobe_wdat", pb_wdat, cur_dat);
        check32("strobe_dir", {30'h0, pb_we, pb_oe}, {30'h0, cur_we, ~cur_we});
      end
      pb_busy = (rem > 0);
      if (rem > 0) rem--;
    end else begin
      active = 1'b0;
      pb_busy = 1'b0;
    end
  end

  // Monitor: exclusivity checks and scoreboard pop on every response.
  always @(negedge clk) begin
    if (rst_n) begin
      check32("ack_err_exclusive", {31'h0, wb_ack & wb_err}, 32'h0);
      check32("we_oe_exclusive", {31'h0, pb_we & pb_oe}, 32'h0);
      if (wb_ack || wb_err) begin
        if (exp_q.size() == 0) begin
          check32("unexpected_resp", {30'h0, wb_ack, wb_err}, 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check32("resp_is_err", {31'h0, wb_err}, {31'h0, e.err});
          check32("resp_data", wb_rdat, e.dat);
        end
      end
    end
  end

  task automatic txn(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                     input logic [31:0] dat, input int nbusy, input bit claim,
                     input logic [31:0] rd, input string tag);
    bit   hit, tmo;
    int   got, bound, exp_lat, exp_strb;
    exp_t e;
    hit = (adr[31:24] == 8'h13);
    tmo = TMO_EN && (nbusy >= TO);
    cfg_busy = nbusy; req_out = claim; pb_rdat = rd;
    cur_we = we; cur_adr = adr[23:0]; cur_sel = sel; cur_dat = dat;
    strobe_cnt = 0; chk_strobe = 1'b1;
    if (hit) begin
      if (tmo) begin
        e.err = 1'b1; e.dat = 32'hFFFF_FFFF;
      end else if (we) begin
        e.err = 1'b0; e.dat = model_dat;
      end else begin
        e.dat = claim ? rd : 32'hFFFF_FFFF;
        e.err = TMO_EN && !claim;
      end
      model_dat = e.dat;
      exp_q.push_back(e);
    end
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_wdat = dat;
    exp_lat  = tmo ? 2 + TO : 3 + nbusy;
    exp_strb = tmo ? TO : nbusy + 1;
    bound = hit ? exp_lat + 8 : 8;
    got = -1;
    for (int i = 1; i <= bound; i++) begin
      @(negedge clk);
      if (wb_ack || wb_err) begin
        got = i;
        break;
      end
    end
    if (hit) begin
      check32({tag, "_latency"}, got, exp_lat);
      check32({tag, "_strobe_cycles"}, strobe_cnt, exp_strb);
      if (got < 0) exp_q.delete();
    end else begin
      check32({tag, "_no_resp"}, got, -1);
      check32({tag, "_no_strobe"}, strobe_cnt, 0);
    end
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    chk_strobe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check32({tag, "_ack_err"}, {30'h0, wb_ack, wb_err}, 32'h0);
    check32({tag, "_rdat"}, wb_rdat, 32'h0);
    check32({tag, "_we_oe"}, {30'h0, pb_we, pb_oe}, 32'h0);
    check32({tag, "_addr"}, {8'h0, pb_adr}, 32'h0);
    check32({tag, "_sel"}, {28'h0, pb_sel}, 32'h0);
    check32({tag, "_wdat"}, pb_wdat, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    logic [7:0] hi;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    txn(1'b1, 32'h1300_0104, 4'hF, 32'hDEAD_BEEF, 0, 1'b0, 32'h0, "wr_basic");
    txn(1'b0, 32'h1300_0200, 4'hF, 32'h0, 0, 1'b1, 32'h0000_00A5, "rd_basic");
    idle(2);
    txn(1'b0, 32'h1300_0300, 4'h3, 32'h1234_5678, 3, 1'b1, 32'hCAFE_0001, "rd_busy3");
    txn(1'b1, 32'h1300_0008, 4'h1, 32'h0BAD_F00D, 2, 1'b1, 32'h5555_5555, "wr_b2b");
    txn(1'b0, 32'h1300_0400, 4'hF, 32'h0, 1, 1'b0, 32'h0000_1111, "rd_unclaimed");
    txn(1'b0, 32'h1400_0000, 4'hF, 32'h0, 0, 1'b1, 32'h0000_2222, "miss_window");
    txn(1'b1, 32'h13FF_FFFC, 4'h8, 32'h8000_0001, 0, 1'b1, 32'h0, "wr_top_addr");
`ifdef PERIPHERAL_BUS_TIMEOUT_EN
    txn(1'b0, 32'h1300_0500, 4'hF, 32'h0, 1000, 1'b1, 32'h0000_3333, "rd_timeout");
    idle(2);
    txn(1'b0, 32'h1300_0504, 4'hF, 32'h0, TO - 1, 1'b1, 32'h0000_4444, "rd_just_in_time");
`endif

    // Abort: cycle dropped while the access is stalled.
    cfg_busy = 10; req_out = 1'b1; pb_rdat = 32'h7777_7777;
    cur_we = 1'b0; cur_adr = 24'h000600; cur_sel = 4'hF; cur_dat = 32'h0;
    chk_strobe = 1'b1; strobe_cnt = 0;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h1300_0600; wb_sel = 4'hF; wb_wdat = '0;
    repeat (2) @(negedge clk);
    check32("abort_oe_before", {31'h0, pb_oe}, 32'h1);
    @(posedge clk); #1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    repeat (2) @(negedge clk);
    check32("abort_strobes_low", {30'h0, pb_we, pb_oe}, 32'h0);
    hit = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (wb_ack || wb_err) hit = 1'b1;
    end
    check32("abort_no_resp", {31'h0, hit}, 32'h0);
    chk_strobe = 1'b0;
    idle(1);

    // Reset asserted mid-access clears everything immediately.
    cfg_busy = 10; cur_adr = 24'h000700; chk_strobe = 1'b1;
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 32'h1300_0700;
    repeat (2) @(negedge clk);
    check32("rst_oe_before", {31'h0, pb_oe}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("rst_async");
    chk_strobe = 1'b0;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    model_dat = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] adr;
      hi = ($urandom_range(0, 99) < 85) ? 8'h13 : 8'($urandom_range(0, 255));
      if (hi == 8'h13 && $urandom_range(0, 99) >= 85) hi = 8'h14;
      adr = {hi, 24'($urandom)};
      txn(1'($urandom), adr, 4'($urandom), $urandom, $urandom_range(0, 4),
          1'($urandom), $urandom, "rand");
      idle($urandom_range(0, 2));
    end

    idle(3);
    check32("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
